// File: rtl/exu_gpr_dbg_pkg.sv
// Shared types for the debug-side GPR access engine.
//   - GPR geometry (index width, data width)
//   - debug command opcodes, engine FSM states
//   - response payload struct carried on the response channel
package exu_gpr_dbg_pkg;

  localparam int unsigned RV_GPR_AW = 5;
  localparam int unsigned RV_XLEN   = 32;

  // Debug command opcodes as carried on req_op.
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DUMP  = 2'b10,
    OP_RSVD  = 2'b11
  } dbg_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_GNT = 2'b01,
    ST_ACCESS   = 2'b10,
    ST_RSP      = 2'b11
  } dbg_state_e;

  // Response payload held stable while rsp_vld is up.
  typedef struct packed {
    logic [RV_GPR_AW-1:0] addr;
    logic [RV_XLEN-1:0]   data;
    logic                 last;
    logic                 err;
  } dbg_rsp_t;

  // Ops that use the GPR read port.
  function automatic logic op_reads(input dbg_op_e op);
    return (op == OP_READ) || (op == OP_DUMP);
  endfunction

endpackage

// File: rtl/exu_gpr_r_if_t.sv
// GPR read port: master drives vld/addr, register file returns data combinationally.
interface exu_gpr_r_if_t;
  import exu_gpr_dbg_pkg::*;

  logic                 vld;
  logic [RV_GPR_AW-1:0] addr;
  logic [RV_XLEN-1:0]   data;

  modport mst (output vld, output addr, input data);
  modport slv (input vld, input addr, output data);
endinterface

// File: rtl/exu_gpr_w_if_t.sv
// GPR write port: master drives wen/addr/data, register file writes at the clock edge.
interface exu_gpr_w_if_t;
  import exu_gpr_dbg_pkg::*;

  logic                 wen;
  logic [RV_GPR_AW-1:0] addr;
  logic [RV_XLEN-1:0]   data;

  modport mst (output wen, output addr, output data);
  modport slv (input wen, input addr, input data);
endinterface

// File: rtl/exu_gpr_dbg_acc.sv
// Debug access engine for the EXU GPR file.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_vld/req_rdy/req_op/addr/wdata  command channel (READ, WRITE, DUMP, reserved)
//   rsp_vld/rsp_rdy/rsp_addr/data/last/err  response channel
//   chn_req/chn_gnt                 arbitration for one GPR mux channel
//   gpr_r_mst, gpr_w_mst            master side of the GPR read/write ports
// Every output is a flop computed from the next state, so strobes line up
// exactly with the state they belong to.
module exu_gpr_dbg_acc
  import exu_gpr_dbg_pkg::*;
#(
  parameter int unsigned DUMP_LAST = 2**RV_GPR_AW - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic [1:0]           req_op,
  input  logic [RV_GPR_AW-1:0] req_addr,
  input  logic [RV_XLEN-1:0]   req_wdata,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic [RV_GPR_AW-1:0] rsp_addr,
  output logic [RV_XLEN-1:0]   rsp_data,
  output logic                 rsp_last,
  output logic                 rsp_err,
  output logic                 chn_req,
  input  logic                 chn_gnt,
  exu_gpr_r_if_t.mst           gpr_r_mst,
  exu_gpr_w_if_t.mst           gpr_w_mst
);

  dbg_state_e           state_q, state_d;
  dbg_op_e              op_q, op_d;
  logic [RV_GPR_AW-1:0] addr_q, addr_d;
  logic [RV_XLEN-1:0]   wdata_q, wdata_d;
  logic [RV_GPR_AW-1:0] idx_q, idx_d;
  dbg_rsp_t             rsp_q, rsp_d;

  logic                 req_rdy_q, req_rdy_d;
  logic                 rsp_vld_q, rsp_vld_d;
  logic                 chn_req_q, chn_req_d;
  logic                 rd_vld_q, rd_vld_d;
  logic [RV_GPR_AW-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_en_q, wr_en_d;
  logic [RV_GPR_AW-1:0] wr_addr_q, wr_addr_d;
  logic [RV_XLEN-1:0]   wr_data_q, wr_data_d;

  logic                 idx_last;
  logic                 access_d;

  // Terminal dump index found by comparison; the counter never wraps.
  assign idx_last = (idx_q == RV_GPR_AW'(DUMP_LAST));

  // State register and all output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      rsp_q     <= '0;
      req_rdy_q <= 1'b1;
      rsp_vld_q <= 1'b0;
      chn_req_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      idx_q     <= idx_d;
      rsp_q     <= rsp_d;
      req_rdy_q <= req_rdy_d;
      rsp_vld_q <= rsp_vld_d;
      chn_req_q <= chn_req_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state, command latch, index counter and response capture.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    rsp_d   = rsp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_vld && req_rdy_q) begin
          op_d    = dbg_op_e'(req_op);
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (op_d == OP_RSVD) begin
            // Reserved op answers immediately without touching the channel.
            rsp_d   = '{addr: req_addr, data: '0, last: 1'b1, err: 1'b1};
            state_d = ST_RSP;
          end else begin
            if (op_d == OP_DUMP) idx_d = '0;
            state_d = ST_WAIT_GNT;
          end
        end
      end
      ST_WAIT_GNT: begin
        if (chn_gnt) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        rsp_d.addr = (op_q == OP_DUMP) ? idx_q : addr_q;
        rsp_d.data = op_reads(op_q) ? gpr_r_mst.data : '0;
        rsp_d.last = (op_q != OP_DUMP) || idx_last;
        rsp_d.err  = 1'b0;
        state_d    = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_rdy) begin
          if ((op_q == OP_DUMP) && !idx_last) begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output flops follow the state being entered; the channel stays claimed
  // from WAIT_GNT through the last response so a dump is never interleaved.
  always_comb begin
    access_d  = (state_d == ST_ACCESS);
    req_rdy_d = (state_d == ST_IDLE);
    rsp_vld_d = (state_d == ST_RSP);
    chn_req_d = (state_d != ST_IDLE) && (op_d != OP_RSVD);
    rd_vld_d  = access_d && op_reads(op_d);
    rd_addr_d = '0;
    if (rd_vld_d) rd_addr_d = (op_d == OP_DUMP) ? idx_d : addr_d;
    wr_en_d   = access_d && (op_d == OP_WRITE);
    wr_addr_d = wr_en_d ? addr_d : '0;
    wr_data_d = wr_en_d ? wdata_d : '0;
  end

  assign req_rdy        = req_rdy_q;
  assign rsp_vld        = rsp_vld_q;
  assign rsp_addr       = rsp_q.addr;
  assign rsp_data       = rsp_q.data;
  assign rsp_last       = rsp_q.last;
  assign rsp_err        = rsp_q.err;
  assign chn_req        = chn_req_q;
  assign gpr_r_mst.vld  = rd_vld_q;
  assign gpr_r_mst.addr = rd_addr_q;
  assign gpr_w_mst.wen  = wr_en_q;
  assign gpr_w_mst.addr = wr_addr_q;
  assign gpr_w_mst.data = wr_data_q;

endmodule

// File: tb/tb_exu_gpr_dbg_acc.sv
// Scoreboard bench for exu_gpr_dbg_acc with a behavioural GPR file.
module tb_exu_gpr_dbg_acc;
  import exu_gpr_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [1:0]  req_op = 2'b00;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b1;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        chn_req;
  logic        chn_gnt = 1'b1;

  exu_gpr_r_if_t r_if ();
  exu_gpr_w_if_t w_if ();

  exu_gpr_dbg_acc dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .chn_req(chn_req), .chn_gnt(chn_gnt),
    .gpr_r_mst(r_if), .gpr_w_mst(w_if)
  );

  always #5 clk = ~clk;

  // Behavioural register file; x0 discards writes.
  logic [31:0] mem [32];
  int          pre_mode = 0;
  logic [4:0]  pre_addr = '0;
  logic [31:0] pre_val = '0;
  assign r_if.data = mem[r_if.addr];
  always @(posedge clk) begin
    if (pre_mode == 1) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i * 3);
    end else if (pre_mode == 2) begin
      mem[pre_addr] <= pre_val;
    end else if (w_if.wen && (w_if.addr != 5'd0)) begin
      mem[w_if.addr] <= w_if.data;
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int rise_cyc = 0;
  int hs_cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int chn_cnt = 0;
  int rdy_mode = 0;
  bit dump_watch = 1'b0;
  logic [4:0]  wr_last_addr = '0;
  logic [31:0] wr_last_data = '0;
  dbg_rsp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // rsp_rdy pattern: 0 = always ready, 1 = random, 2 = stalled.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       rsp_rdy = 1'b1;
      1:       rsp_rdy = 1'($urandom_range(0, 1));
      default: rsp_rdy = 1'b0;
    endcase
  end

  // Monitor: strobe counters, stability while stalled, scoreboard pop.
  initial begin
    dbg_rsp_t e;
    dbg_rsp_t stall_val;
    bit       stall_prev;
    bit       prev_vld;
    stall_prev = 1'b0;
    prev_vld   = 1'b0;
    stall_val  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
        prev_vld   = 1'b0;
      end else begin
        if (r_if.vld) rd_cnt++;
        if (w_if.wen) begin
          wr_cnt++;
          wr_last_addr = w_if.addr;
          wr_last_data = w_if.data;
        end
        if (chn_req) chn_cnt++;
        if (dump_watch) chk("dump_chn_req_held", 64'(chn_req), 64'd1);
        if (rsp_vld && !prev_vld) rise_cyc = cyc;
        if (stall_prev && rsp_vld)
          chk("rsp_stable", 64'({rsp_addr, rsp_data, rsp_last, rsp_err}), 64'(stall_val));
        if (rsp_vld && rsp_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got addr=%0d data=0x%0h, none expected", rsp_addr, rsp_data);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_addr", 64'(rsp_addr), 64'(e.addr));
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
            chk("rsp_last", 64'(rsp_last), 64'(e.last));
            chk("rsp_err",  64'(rsp_err),  64'(e.err));
          end
          rsp_cnt++;
        end
        stall_prev = rsp_vld && !rsp_rdy;
        stall_val  = '{addr: rsp_addr, data: rsp_data, last: rsp_last, err: rsp_err};
        prev_vld   = rsp_vld;
      end
    end
  end

  task automatic push(input logic [4:0] a, input logic [31:0] d, input logic l, input logic er);
    exp_q.push_back('{addr: a, data: d, last: l, err: er});
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    req_vld = 1'b1; req_op = op; req_addr = a; req_wdata = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_rdy) begin
        ok = 1'b1;
        hs_cyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL req_accept: req_rdy stayed 0, required 1 within 50 cycles");
    end
  endtask

  task automatic wait_rsp(input int target, input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rsp_cnt >= target) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: responses=%0d required=%0d", nm, rsp_cnt, target);
    end
  endtask

  task automatic preload(input int mode, input logic [4:0] a, input logic [31:0] v);
    @(posedge clk);
    #1;
    pre_mode = mode; pre_addr = a; pre_val = v;
    @(posedge clk);
    #1;
    pre_mode = 0;
  endtask

  initial begin
    int rd0, wr0, chn0, g;
    bit seen;

    preload(1, 5'd0, 32'd0);
    chk("rst_req_rdy",  64'(req_rdy),  64'd1);
    chk("rst_rsp_vld",  64'(rsp_vld),  64'd0);
    chk("rst_chn_req",  64'(chn_req),  64'd0);
    chk("rst_rsp_bus",  64'({rsp_addr, rsp_data, rsp_last, rsp_err}), 64'd0);
    chk("rst_gpr_strb", 64'({r_if.vld, w_if.wen, r_if.addr, w_if.addr}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // READ x5 with immediate grant.
    preload(2, 5'd5, 32'hDEADBEEF);
    rd0 = rd_cnt;
    push(5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    issue(OP_READ, 5'd5, 32'd0);
    wait_rsp(1, "read_x5");
    chk("read_latency", 64'(rise_cyc - hs_cyc), 64'd3);
    chk("read_vld_pulses", 64'(rd_cnt - rd0), 64'd1);

    // WRITE x7 then READ x7.
    wr0 = wr_cnt;
    push(5'd7, 32'd0, 1'b1, 1'b0);
    issue(OP_WRITE, 5'd7, 32'h12345678);
    wait_rsp(2, "write_x7");
    chk("write_wen_pulses", 64'(wr_cnt - wr0), 64'd1);
    chk("write_addr", 64'(wr_last_addr), 64'd7);
    chk("write_data", 64'(wr_last_data), 64'h12345678);
    chk("write_latency", 64'(rise_cyc - hs_cyc), 64'd3);
    push(5'd7, 32'h12345678, 1'b1, 1'b0);
    issue(OP_READ, 5'd7, 32'd0);
    wait_rsp(3, "read_x7");

    // WRITE x0 is issued but discarded.
    wr0 = wr_cnt;
    push(5'd0, 32'd0, 1'b1, 1'b0);
    issue(OP_WRITE, 5'd0, 32'hFFFFFFFF);
    wait_rsp(4, "write_x0");
    chk("write_x0_wen", 64'(wr_cnt - wr0), 64'd1);
    push(5'd0, 32'd0, 1'b1, 1'b0);
    issue(OP_READ, 5'd0, 32'd0);
    wait_rsp(5, "read_x0");

    // DUMP with random backpressure.
    preload(1, 5'd0, 32'd0);
    for (int i = 0; i < 32; i++) push(5'(i), 32'(i * 3), 1'(i == 31), 1'b0);
    rd0 = rd_cnt;
    rdy_mode = 1;
    issue(OP_DUMP, 5'd10, 32'd0);
    dump_watch = 1'b1;
    wait_rsp(37, "dump");
    dump_watch = 1'b0;
    rdy_mode = 0;
    chk("dump_reads", 64'(rd_cnt - rd0), 64'd32);
    @(negedge clk);
    chk("dump_chn_released", 64'(chn_req), 64'd0);
    chk("dump_req_rdy", 64'(req_rdy), 64'd1);

    // Grant withheld for 10 cycles.
    chn_gnt = 1'b0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    push(5'd9, 32'd27, 1'b1, 1'b0);
    issue(OP_READ, 5'd9, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("nognt_req_rdy", 64'(req_rdy), 64'd0);
    end
    chk("nognt_chn_req", 64'(chn_req), 64'd1);
    chk("nognt_strobes", 64'((rd_cnt - rd0) + (wr_cnt - wr0)), 64'd0);
    chk("nognt_no_rsp", 64'(rsp_cnt), 64'd37);
    @(posedge clk);
    #1;
    chn_gnt = 1'b1;
    g = cyc;
    wait_rsp(38, "gnt_wait");
    chk("gnt_to_rsp", 64'(rise_cyc - g), 64'd2);

    // Reserved op.
    chn0 = chn_cnt;
    push(5'd3, 32'd0, 1'b1, 1'b1);
    issue(OP_RSVD, 5'd3, 32'hA5A5A5A5);
    wait_rsp(39, "rsvd");
    chk("rsvd_latency", 64'(rise_cyc - hs_cyc), 64'd1);
    chk("rsvd_no_chn_req", 64'(chn_cnt - chn0), 64'd0);

    // Reset during a stalled dump.
    rdy_mode = 2;
    issue(OP_DUMP, 5'd0, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_vld) begin
        seen = 1'b1;
        break;
      end
    end
    chk("stall_rsp_vld", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_rdy", 64'(req_rdy), 64'd1);
    chk("arst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("arst_chn_req", 64'(chn_req), 64'd0);
    chk("arst_rsp_bus", 64'({rsp_addr, rsp_data, rsp_last, rsp_err}), 64'd0);
    chk("arst_gpr_strb", 64'({r_if.vld, w_if.wen}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    push(5'd12, 32'd36, 1'b1, 1'b0);
    issue(OP_READ, 5'd12, 32'd0);
    wait_rsp(40, "post_reset_read");
    chk("post_reset_latency", 64'(rise_cyc - hs_cyc), 64'd3);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
